// File: rtl/uart_pkg.sv
// Shared UART constants and the receive FIFO entry format.
package uart_pkg;

  localparam int UART_DATA_W        = 8;
  localparam int UART_RX_FIFO_DEPTH = 16;

  typedef struct packed {
    logic                   err;
    logic [UART_DATA_W-1:0] data;
  } uart_rx_entry_t;

endpackage

// File: rtl/uart_rise_detect.sv
// Single-cycle rising-edge detector.
// The history register resets high so a level already asserted at reset
// release is not treated as an edge.
module uart_rise_detect (
  input  logic clk,
  input  logic reset_n,
  input  logic level,
  output logic rise
);

  logic level_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      level_q <= 1'b1;
    end else begin
      level_q <= level;
    end
  end

  assign rise = level & ~level_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side first-word-fall-through byte FIFO behind the UART receiver.
// It also keeps a sticky overrun flag and a saturating receive-error counter.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = UART_RX_FIFO_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                   rx_clock,
  input  logic                   rx_reset_n,
  input  logic                   rx_done,
  input  logic                   rx_error,
  input  logic [UART_DATA_W-1:0] rx_output,
  input  logic                   rd_en,
  input  logic                   clr_status,
  output logic [UART_DATA_W-1:0] rd_data,
  output logic                   rd_err,
  output logic                   empty,
  output logic                   full,
  output logic [ADDR_W:0]        count,
  output logic                   overrun,
  output logic [7:0]             err_count
);

  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

  uart_rx_entry_t  mem [DEPTH];
  logic [ADDR_W:0] wptr;
  logic [ADDR_W:0] rptr;
  logic            push;
  logic            err_rise;
  logic            pop;
  logic            write_ok;
  uart_rx_entry_t  head;

  uart_rise_detect u_done_rise (
    .clk     (rx_clock),
    .reset_n (rx_reset_n),
    .level   (rx_done),
    .rise    (push)
  );

  uart_rise_detect u_err_rise (
    .clk     (rx_clock),
    .reset_n (rx_reset_n),
    .level   (rx_error),
    .rise    (err_rise)
  );

  assign count    = wptr - rptr;
  assign empty    = (count == '0);
  assign full     = (count == FULL_COUNT);
  assign pop      = rd_en & ~empty;
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign write_ok = push & (~full | pop);

  assign head    = mem[rptr[ADDR_W-1:0]];
  assign rd_data = empty ? '0 : head.data;
  assign rd_err  = empty ? 1'b0 : head.err;

  always_ff @(posedge rx_clock) begin
    if (write_ok) begin
      mem[wptr[ADDR_W-1:0]] <= '{err: rx_error, data: rx_output};
    end
  end

  always_ff @(posedge rx_clock) begin
    if (!rx_reset_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (write_ok) begin
        wptr <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
    end
  end

  // Clear takes priority over a coincident overrun or error edge.
  always_ff @(posedge rx_clock) begin
    if (!rx_reset_n) begin
      overrun   <= 1'b0;
      err_count <= '0;
    end else if (clr_status) begin
      overrun   <= 1'b0;
      err_count <= '0;
    end else begin
      if (push && full && !pop) begin
        overrun <= 1'b1;
      end
      if (err_rise && err_count != 8'hFF) begin
        err_count <= err_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo against a queue-based reference model.
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;

  logic       rx_clock = 1'b0;
  logic       rx_reset_n = 1'b0;
  logic       rx_done = 1'b0;
  logic       rx_error = 1'b0;
  logic [7:0] rx_output = 8'h00;
  logic       rd_en = 1'b0;
  logic       clr_status = 1'b0;
  logic [7:0] rd_data;
  logic       rd_err;
  logic       empty;
  logic       full;
  logic [4:0] count;
  logic       overrun;
  logic [7:0] err_count;

  int checks = 0;
  int errors = 0;

  logic [8:0] mq[$];
  bit         m_done_q = 1'b1;
  bit         m_err_q = 1'b1;
  bit         m_ovr = 1'b0;
  int         m_err_cnt = 0;
  int         m_pushes = 0;
  string      phase = "init";

  uart_rx_fifo #(.DEPTH(DEPTH)) dut (
    .rx_clock   (rx_clock),
    .rx_reset_n (rx_reset_n),
    .rx_done    (rx_done),
    .rx_error   (rx_error),
    .rx_output  (rx_output),
    .rd_en      (rd_en),
    .clr_status (clr_status),
    .rd_data    (rd_data),
    .rd_err     (rd_err),
    .empty      (empty),
    .full       (full),
    .count      (count),
    .overrun    (overrun),
    .err_count  (err_count)
  );

  always #5 rx_clock = ~rx_clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s/%s observed=%0h expected=%0h", phase, tag, observed, expected);
    end
  endtask

  // Reference model: advance one clock using the inputs currently driven.
  task automatic modelStep();
    bit push, rise, pop;
    if (!rx_reset_n) begin
      mq.delete();
      m_done_q = 1'b1;
      m_err_q = 1'b1;
      m_ovr = 1'b0;
      m_err_cnt = 0;
    end else begin
      push = rx_done && !m_done_q;
      rise = rx_error && !m_err_q;
      pop  = rd_en && (mq.size() > 0);
      if (pop) void'(mq.pop_front());
      if (push) begin
        m_pushes++;
        if (mq.size() < DEPTH) mq.push_back({rx_error, rx_output});
        else m_ovr = 1'b1;
      end
      if (rise && m_err_cnt < 255) m_err_cnt++;
      if (clr_status) begin
        m_ovr = 1'b0;
        m_err_cnt = 0;
      end
      m_done_q = rx_done;
      m_err_q = rx_error;
    end
  endtask

  task automatic compareAll();
    logic [8:0] head;
    head = (mq.size() > 0) ? mq[0] : 9'h000;
    checkOutput("rd_data", rd_data, head[7:0]);
    checkOutput("rd_err", rd_err, head[8]);
    checkOutput("empty", empty, mq.size() == 0);
    checkOutput("full", full, mq.size() == DEPTH);
    checkOutput("count", count, mq.size());
    checkOutput("overrun", overrun, m_ovr);
    checkOutput("err_count", err_count, m_err_cnt);
  endtask

  task automatic applyStimulus(input logic done, input logic err, input logic [7:0] data,
                               input logic rd, input logic clr);
    rx_done = done;
    rx_error = err;
    rx_output = data;
    rd_en = rd;
    clr_status = clr;
    modelStep();
    @(posedge rx_clock);
    #1;
    compareAll();
  endtask

  task automatic pushByte(input logic [7:0] data, input logic err);
    applyStimulus(1'b1, err, data, 1'b0, 1'b0);
    applyStimulus(1'b1, err, data, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, data, 1'b0, 1'b0);
  endtask

  initial begin
    logic [7:0] last_read;

    phase = "reset_high";
    rx_reset_n = 1'b0;
    applyStimulus(1'b1, 1'b1, 8'h77, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 8'h77, 1'b0, 1'b0);
    rx_reset_n = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 8'h77, 1'b0, 1'b0);
    checkOutput("no_push_empty", empty, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

    phase = "single";
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1'b0, 8'h55, 1'b0, 1'b0);
    checkOutput("one_entry", count, 5'd1);
    checkOutput("head_55", rd_data, 8'h55);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("popped_empty", empty, 1'b1);

    phase = "overrun";
    for (int i = 0; i < 17; i++) pushByte(8'(i), 1'b0);
    checkOutput("ovr_set", overrun, 1'b1);
    checkOutput("ovr_full", full, 1'b1);
    for (int i = 0; i < 16; i++) begin
      checkOutput("drain_order", rd_data, 8'(i));
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    end
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("ovr_cleared", overrun, 1'b0);

    phase = "full_push_pop";
    for (int i = 0; i < 16; i++) pushByte(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    applyStimulus(1'b1, 1'b0, 8'hA5, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'hA5, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("count_16", count, 5'd16);
    checkOutput("no_ovr", overrun, 1'b0);
    last_read = 8'h00;
    for (int i = 0; i < 16; i++) begin
      last_read = rd_data;
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    end
    checkOutput("last_a5", last_read, 8'hA5);

    phase = "err_sat";
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    end
    checkOutput("err_255", err_count, 8'd255);
    applyStimulus(1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
    checkOutput("err_clr_wins", err_count, 8'd0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

    phase = "random_wrap";
    m_pushes = 0;
    for (int cyc = 0; cyc < 2000 && m_pushes < 40; cyc++) begin
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b0);
    end
    checkOutput("random_pushes", m_pushes >= 40, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    pushByte(8'h3C, 1'b1);
    checkOutput("pre_reset_nonempty", empty, 1'b0);

    phase = "mid_reset";
    rx_reset_n = 1'b0;
    applyStimulus(1'b1, 1'b0, 8'h99, 1'b0, 1'b0);
    rx_reset_n = 1'b1;
    checkOutput("reset_empty", empty, 1'b1);
    checkOutput("reset_rd_data", rd_data, 8'h00);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side byte buffer that sits directly downstream of the UART receiver FSM in the `rx_clock` domain. Captures each completed byte on the rising edge of the receiver's `rx_done` level (which stays high for up to 16 cycles), stores it with its error tag in a first-word-fall-through FIFO, and exposes a pop interface to the host side. Also keeps sticky overrun status and a saturating receive-error counter.

## Interface

Parameters:
- `DEPTH`, 16: number of byte entries; power of two, at least 2.
- `ADDR_W`, $clog2(DEPTH): pointer width, derived, not overridden.

Ports (one clock; reset is synchronous and active-low):
- `rx_clock` in 1: the single clock, same 16x-oversample clock as the receiver.
- `rx_reset_n` in 1: synchronous, active-low reset.
- `rx_done` in 1: receiver done level, multi-cycle high.
- `rx_error` in 1: receiver error level.
- `rx_output` in 8: receiver byte, valid while `rx_done` is high.
- `rd_en` in 1: pop the head entry; ignored when `empty`.
- `clr_status` in 1: clears `overrun` and `err_count`.
- `rd_data` out 8: head entry byte, FWFT; 0 when `empty`.
- `rd_err` out 1: error tag of head entry; 0 when `empty`.
- `empty` out 1: FIFO holds no entries.
- `full` out 1: FIFO holds `DEPTH` entries.
- `count` out ADDR_W+1: number of stored entries.
- `overrun` out 1: sticky; a byte was dropped because the FIFO was full.
- `err_count` out 8: count of `rx_error` rising edges, saturating at 255.

## Operation

- Push event: `push = rx_done & ~done_q`, where `done_q` is `rx_done` registered. The entry written is {`rx_error`, `rx_output`}, both sampled in the push cycle.
- Error event: `err_rise = rx_error & ~err_q`. It increments `err_count`, which holds at 255.
- Both edge registers reset to 1, so a level that is already high when reset is released produces no event.
- Pop: `pop = rd_en & ~empty`. It advances the read pointer.
- Pointers are ADDR_W+1 bits wide and wrap naturally. `count = wptr - rptr`, `empty = (count == 0)`, `full = (count == DEPTH)`.
- Push while full:
  - With no pop in the same cycle, the byte is dropped, pointers are unchanged, and `overrun` is set to 1.
  - With a pop in the same cycle, both happen, `count` is unchanged, and no overrun is flagged.
- Push and `rd_en` while empty: the push happens, `rd_en` is ignored, and `count` becomes 1.
- `clr_status` clears `overrun` and `err_count`. A clear in the same cycle as a new overrun or `err_rise` wins, so the result is 0. FIFO contents are not affected.
- Reset values:
  - Pointers 0, `empty` = 1, `full` = 0, `count` = 0.
  - `rd_data` = 0, `rd_err` = 0, `overrun` = 0, `err_count` = 0.
  - `done_q` = 1, `err_q` = 1.
  - Storage contents are not reset.
- Reset asserted mid-operation discards all entries on that edge.

## Timing

- All state updates on `posedge rx_clock`.
- Push latency: `rx_done` rises in cycle N; the entry is written at the end of N. `empty`, `count` and `rd_data` reflect it in cycle N+1.
- Pop: with `rd_en` high in cycle M, the next entry (or 0/`empty`) appears in cycle M+1.
- `rd_data` and `rd_err` are combinational from the storage array at `rptr`, masked by `empty`.
- Consecutive pushes need at least one cycle of `rx_done` low between them. Back-to-back receiver bytes always satisfy this.
- Pops may occur every cycle.

## Structure

- Shared package `uart_pkg`:
  - `UART_DATA_W = 8`
  - `UART_RX_FIFO_DEPTH = 16`
  - typedef `uart_rx_entry_t` = packed {err, data[7:0]}.
- Sub-module `uart_rise_detect` (reset value 1, outputs `in & ~q`). It is instantiated twice, for `rx_done` and for `rx_error`.
- Storage is a plain register array of `uart_rx_entry_t`; no RAM macro.

## Test plan

- Reset release with `rx_done` already high -> no push, `empty` = 1, `count` = 0.
- `rx_output` = 0x55 with `rx_done` held high for 16 cycles -> exactly one entry; in the next cycle `rd_data` = 0x55, `rd_err` = 0, `count` = 1; a pop returns to `empty`.
- 17 bytes 0x00..0x10 pushed with no pops at `DEPTH` = 16 -> `full` = 1, `count` = 16, `overrun` = 1; pops return 0x00..0x0F in order; `clr_status` then gives `overrun` = 0.
- FIFO full, push 0xA5 and `rd_en` in the same cycle -> `count` stays 16, `overrun` stays 0, 0xA5 is the last entry read.
- 300 `rx_error` pulses -> `err_count` = 255; `clr_status` coincident with a pulse gives 0.
- 40 pushes and pops interleaved across pointer wrap -> data order preserved and `count` correct every cycle; reset asserted mid-stream gives `empty` = 1 and `rd_data` = 0 in the next cycle.
